// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo slice.
// Pointer width carries one extra wrap bit above the address.
package fifo_pkg;

  localparam int PF_DEPTH  = 2;
  localparam int MIN_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
// Contents are never reset.
module SdpRamRf #(
  parameter int DW    = 8,
  parameter int WORDS = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic                     re,
  input  logic [$clog2(WORDS)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock valid/ready FIFO over SdpRamRf with a 2-entry prefetch.
// SYNC_FIFO_ALMOST_EN adds registered almost_full/almost_empty flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEPTH     = 256,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
`ifdef SYNC_FIFO_ALMOST_EN
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full,
  output logic                    almost_empty
`else
  output logic [$clog2(DEPTH):0]  count
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  if (DEPTH < MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_cfg
    $error("sync_fifo: bad DEPTH or threshold");
  end

  logic [PW-1:0] wr_ptr, rd_ptr, cnt_nxt;
  logic [1:0]    pf_cnt;
  logic [DW-1:0] pf0, pf1, ram_q;
  logic [2:0]    pf_occ;
  logic          rd_busy, push, pop, ram_has, rd_issue;

  assign in_ready  = rst_n & (count < DEPTH_C);
  assign out_valid = (pf_cnt != 2'd0);
  assign out_data  = pf0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ram_has   = (wr_ptr != rd_ptr);

  // A pop this cycle frees a slot, so back-to-back reads never bubble.
  assign pf_occ   = {1'b0, pf_cnt} + {2'b0, rd_busy} - {2'b0, pop};
  assign rd_issue = ram_has & (pf_occ < 3'(PF_DEPTH));

  always_comb begin
    cnt_nxt = count;
    unique case (1'b1)
      push && !pop: cnt_nxt = count + PW'(1);
      pop && !push: cnt_nxt = count - PW'(1);
      default: ;
    endcase
  end

  SdpRamRf #(
    .DW    (DW),
    .WORDS (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .re    (rd_issue),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_busy <= 1'b0;
      pf_cnt  <= 2'd0;
      pf0     <= '0;
      pf1     <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
      rd_busy <= rd_issue;
      count   <= cnt_nxt;
      case ({pop, rd_busy})
        2'b11: begin
          if (pf_cnt == 2'd2) begin
            pf0 <= pf1;
            pf1 <= ram_q;
          end else begin
            pf0 <= ram_q;
          end
        end
        2'b10: begin
          pf0    <= pf1;
          pf_cnt <= pf_cnt - 2'd1;
        end
        2'b01: begin
          if (pf_cnt == 2'd0) pf0 <= ram_q;
          else                pf1 <= ram_q;
          pf_cnt <= pf_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SYNC_FIFO_ALMOST_EN
  localparam logic [PW-1:0] AF_C = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C = PW'(AE_THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed + random scoreboard bench for sync_fifo, DEPTH=8.
// Almost-flag checks follow SYNC_FIFO_ALMOST_EN.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [3:0]    count;
`ifdef SYNC_FIFO_ALMOST_EN
  logic          almost_full, almost_empty;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cnt_m = 0;
  int n_push = 0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  sync_fifo #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
`ifdef SYNC_FIFO_ALMOST_EN
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`else
    .count        (count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [DW-1:0] d,
                       input logic ordy);
    logic p, q, stall;
    logic [DW-1:0] held, e;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    p     = iv & in_ready;
    q     = out_valid & ordy;
    stall = out_valid & !ordy;
    held  = out_data;
    if (q) begin
      if (sb.size() == 0) begin
        chk("spurious_pop", 32'(out_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("data", 32'(out_data), 32'(e));
      end
    end
    if (p) begin
      sb.push_back(d);
      n_push++;
    end
    @(posedge clk);
    #1;
    cnt_m = cnt_m + int'(p) - int'(q);
    chk("count", 32'(count), 32'(cnt_m));
    chk("count_le_depth", 32'(count <= 4'(DEPTH)), 32'(1));
    if (stall) begin
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_data", 32'(out_data), 32'(held));
    end
`ifdef SYNC_FIFO_ALMOST_EN
    chk("almost_full", 32'(almost_full), 32'(cnt_m >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(cnt_m <= 2));
`endif
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && sb.size() > 0; k++) cycle(1'b0, '0, 1'b1);
    chk("drained", 32'(sb.size()), 32'(0));
    chk("drain_count", 32'(count), 32'(0));
  endtask

  initial begin
    int target;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
`ifdef SYNC_FIFO_ALMOST_EN
    chk("rst_af", 32'(almost_full), 32'(0));
    chk("rst_ae", 32'(almost_empty), 32'(1));
`endif
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'(1));

    // single word: visible two edges after the push edge
    cycle(1'b1, 8'hA5, 1'b1);
    chk("lat_e0", 32'(out_valid), 32'(0));
    cycle(1'b0, '0, 1'b1);
    chk("lat_e1", 32'(out_valid), 32'(0));
    cycle(1'b0, '0, 1'b1);
    chk("lat_e2_valid", 32'(out_valid), 32'(1));
    chk("lat_e2_data", 32'(out_data), 32'(8'hA5));
    cycle(1'b0, '0, 1'b1);
    chk("single_count0", 32'(count), 32'(0));

    // fill to DEPTH, then one refused offer
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    cycle(1'b1, 8'hFF, 1'b0);
    chk("full_refused", 32'(count), 32'(DEPTH));
    chk("full_sb", 32'(sb.size()), 32'(DEPTH));
    drain();

    // streaming: no gaps after the initial latency
    for (int i = 0; i < 100; i++) begin
      if (i >= 3) begin
        #1;
        chk("nogap", 32'(out_valid), 32'(1));
      end
      cycle(1'b1, 8'(i), 1'b1);
      if (i >= 2) chk("steady_count", 32'(count), 32'(3));
    end
    drain();

    // random valid/ready
    target = n_push + 10000;
    for (int k = 0; k < 60000 && n_push < target; k++)
      cycle(1'($urandom_range(1, 0)), 8'($urandom),
            1'($urandom_range(1, 0)));
    chk("rand_done", 32'(n_push >= target), 32'(1));
    drain();

    // reset with count=5 and a read in flight
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    chk("pre_rst_count", 32'(count), 32'(5));
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_data", 32'(out_data), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
    sb.delete();
    cnt_m = 0;
    rst_n = 1'b1;
    cycle(1'b1, 8'h3C, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock FIFO with a valid/ready handshake on both sides. It buffers a producer stream into the team's simple dual-port, registered-read RAM. A 2-entry prefetch buffer hides the RAM read latency and gives the consumer one word per cycle. It sits directly upstream of consumers that need elastic buffering in front of RAM-backed storage.

## Interface
- DW, 8: data width in bits.
- DEPTH, 256: total capacity in words. Power of two, ≥ 4.
- AF_THRESH, DEPTH-2: almost-full threshold. Used only with the macro.
- AE_THRESH, 2: almost-empty threshold. Used only with the macro.

- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DW  write data.
- out_valid  out  1  out_data holds the oldest word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  DW  head-of-queue data.
- count  out  $clog2(DEPTH)+1  words accepted and not yet popped.
- almost_full  out  1  (macro only) count ≥ AF_THRESH.
- almost_empty  out  1  (macro only) count ≤ AE_THRESH.

## Operation
- Push: in_valid & in_ready at an edge. in_data is written to RAM[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: out_valid & out_ready at an edge. The head is removed from the prefetch buffer.
- in_ready = (count < DEPTH) while rst_n is high; in_ready = 0 while rst_n is low. in_ready is combinational from registered count only; it never depends on in_valid.
- count is updated every edge: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop or on neither. count includes RAM words, words in flight in the RAM read, and prefetch-buffer words.
- Prefetch: a RAM read of rd_ptr is issued when the RAM holds unread words and (prefetch occupancy + reads in flight) < 2. rd_ptr increments modulo DEPTH. RAM data is written into the prefetch buffer on the following edge.
- Prefetch buffer: 2-entry in-order queue. out_data and out_valid come from its head register, not from the RAM output.
- RAM unread-word tracking uses pointers with an extra wrap bit. Empty: pointers fully equal. Full: only the MSB differs.
- Simultaneous push and pop at count=DEPTH: the pop frees a slot only from the next edge on, because in_ready is still 0 this cycle. No overflow is possible.
- Push to an empty FIFO: no bypass. The word always goes through the RAM.
- Reset asserted mid-operation: contents are discarded and any in-flight read is dropped. On the next edge after rst_n is low: pointers = 0, count = 0, prefetch empty, out_valid = 0, out_data = 0, in_ready = 0. RAM contents are not cleared.

## Timing
- Reset values: in_ready 0 (1 from the first cycle after rst_n goes high), out_valid 0, out_data 0, count 0, almost_full 0, almost_empty 1.
- Latency from push at edge E0 into an empty FIFO: read issued in cycle E0..E1 and captured at E1; data lands in the prefetch buffer at E2. out_valid is high after E2, so latency is 2 cycles.
- Throughput: 1 push and 1 pop per cycle sustained, with no bubbles once count ≥ 3.
- out_valid/out_data are stable while out_valid & !out_ready.
- count changes one edge after the handshake.

## Configuration
- Macro: SYNC_FIFO_ALMOST_EN.
- Defined: almost_full and almost_empty ports are present, registered, and updated on the same edge as count (derived from next-count).
- Undefined: both ports and their logic are absent. AF_THRESH/AE_THRESH remain parameters but are unused.

## Structure
- Package fifo_pkg holds:
  - the pointer-width helper function (returns $clog2(DEPTH)+1);
  - the prefetch-depth constant PF_DEPTH = 2;
  - the minimum-depth constant MIN_DEPTH = 4, checked by an elaboration assertion.
- Sub-module: SdpRamRf (simple dual-port, registered read), instantiated once with DW and WORDS = DEPTH. The write port is driven by the push logic and the read port by the prefetch logic.
- Pointer/count logic and the prefetch queue live in sync_fifo itself.

## Test plan
- Reset, then single push of 0xA5 with out_ready=1: out_valid rises exactly 2 cycles after the push edge, out_data=0xA5, count goes 0→1→0.
- Fill DEPTH=8 with 0..7 and out_ready=0: in_ready drops after the 8th push and count=8. An extra in_valid is not accepted. Draining then yields 0..7 in order.
- Continuous push and pop with both valid/ready held high for 100 words: after the initial latency, one word per cycle with no gaps, in order, and count stays constant.
- Random in_valid/out_ready (50%) over 10k words: scoreboard order matches, count never exceeds DEPTH, out_data holds while stalled.
- Reset asserted with count=5 and a read in flight: next cycle count=0, out_valid=0, out_data=0. The next push after reset returns that new word, not stale data.
- SYNC_FIFO_ALMOST_EN with DEPTH=8, AF=6, AE=2: almost_full sets on the edge count becomes 6 and almost_empty clears on the edge count becomes 3.
